// File: rtl/sram_burst_arbiter.sv
// Two-requester burst arbiter/sequencer owning a single-port synchronous SRAM.
// Latency: arbitration cycle, then one beat per cycle; read data one cycle after its beat.
// Backpressure: none; requests sampled only in IDLE, one IDLE bubble between bursts.
// Optional feature: define SRAM_BURST_ARBITER_RR_EN for round-robin contention,
// otherwise port 0 has fixed priority.
module sram_burst_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [LEN_W-1:0]  p0_len,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_beat,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [LEN_W-1:0]  p1_len,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_beat,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               cur_we;
    logic [ADDR_W-1:0]  cur_addr;
    logic [LEN_W-1:0]   cnt;
    logic               owner;
    logic               any_req;
    logic               winner;
    logic               grant;
    logic               last_beat;

    assign any_req   = p0_req | p1_req;
    assign grant     = (state == IDLE) && any_req;
    assign last_beat = (state == BURST) && (cnt == '0);

`ifdef SRAM_BURST_ARBITER_RR_EN
    logic last_owner;

    // On contention the port that did not win last time goes next.
    assign winner = (p0_req && p1_req) ? ~last_owner : ~p0_req;

    // Remember the most recent grant for the round-robin decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner <= 1'b1;
        end else if (grant) begin
            last_owner <= winner;
        end
    end
`else
    // Port 0 wins whenever it is requesting.
    assign winner = ~p0_req;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the combinational SRAM/beat outputs; IDLE drives all zeros.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        p0_beat   = 1'b0;
        p1_beat   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                mem_en   = 1'b1;
                mem_we   = cur_we;
                mem_addr = cur_addr;
                if (cur_we) begin
                    mem_wdata = owner ? p1_wdata : p0_wdata;
                end
                p0_beat = ~owner;
                p1_beat = owner;
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst descriptor: latched at grant, then address steps up and count steps down per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_we   <= 1'b0;
            cur_addr <= '0;
            cnt      <= '0;
            owner    <= 1'b0;
        end else if (grant) begin
            cur_we   <= winner ? p1_we   : p0_we;
            cur_addr <= winner ? p1_addr : p0_addr;
            cnt      <= winner ? p1_len  : p0_len;
            owner    <= winner;
        end else if (state == BURST) begin
            cur_addr <= cur_addr + 1'b1;
            cnt      <= cnt - 1'b1;
        end
    end

    // Grants rise with entry to BURST and fall after the last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_gnt <= 1'b0;
            p1_gnt <= 1'b0;
        end else if (grant) begin
            p0_gnt <= ~winner;
            p1_gnt <= winner;
        end else if (last_beat) begin
            p0_gnt <= 1'b0;
            p1_gnt <= 1'b0;
        end
    end

    // Read-valid flags trail each read beat by one cycle, matching SRAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= (state == BURST) && !cur_we && !owner;
            p1_rvalid <= (state == BURST) && !cur_we && owner;
        end
    end

    assign p0_rdata = p0_rvalid ? mem_rdata : '0;
    assign p1_rdata = p1_rvalid ? mem_rdata : '0;

endmodule
